// File: rtl/fb_pkg.sv
// Shared constants, command encodings and FSM state type for the 1-bpp framebuffer.
package fb_pkg;
   localparam int FB_W          = 320;
   localparam int FB_H          = 200;
   localparam int WORD_W        = 16;
   localparam int WORDS_PER_ROW = FB_W / WORD_W;
   localparam int FB_WORDS      = FB_H * WORDS_PER_ROW;
   localparam int ADDR_W        = 12;
   localparam int BIT_W         = 4;

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_TGL = 2'b10;
   localparam logic [1:0] OP_CLS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_CLR
   } fb_state_t;
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous RAM: port A read-only (scanout), port B read/write
// with read-before-write. No reset on contents so it maps onto block RAM.
module fb_ram
   import fb_pkg::*;
#(
   parameter int DEPTH = FB_WORDS,
   parameter int AW    = ADDR_W,
   parameter int DW    = WORD_W
) (
   input  logic          clk,
   input  logic [AW-1:0] addr_a,
   output logic [DW-1:0] q_a,
   input  logic [AW-1:0] addr_b,
   input  logic          we_b,
   input  logic [DW-1:0] d_b,
   output logic [DW-1:0] q_b
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      q_a <= mem[addr_a];
   end

   always_ff @(posedge clk) begin
      if (we_b) begin
         mem[addr_b] <= d_b;
      end
      q_b <= mem[addr_b];
   end

endmodule

// File: rtl/framebuffer.sv
// 320x200 1-bpp framebuffer: registered scanout read port plus a valid/ready
// pixel/clear-screen command port. Define FB_TOGGLE_EN to enable the toggle op.
module framebuffer
   import fb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] x_a,
   input  logic [7:0] y_a,
   output logic       in_a,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_op,
   input  logic [8:0] wr_x,
   input  logic [7:0] wr_y,
   output logic       busy
);

   function automatic logic in_range(input logic [8:0] x, input logic [7:0] y);
      return (x < 9'(FB_W)) && (y < 8'(FB_H));
   endfunction

   function automatic logic [ADDR_W-1:0] word_addr(input logic [8:0] x, input logic [7:0] y);
      return (ADDR_W'(y) * ADDR_W'(WORDS_PER_ROW)) + ADDR_W'(x[8:4]);
   endfunction

   function automatic logic [WORD_W-1:0] merge_bit(input logic [WORD_W-1:0] word,
                                                   input logic [BIT_W-1:0]  idx,
                                                   input logic [1:0]        op);
      logic [WORD_W-1:0] mask;
      logic [WORD_W-1:0] res;
      mask = WORD_W'(1) << idx;
      res  = word;
      case (op)
         OP_CLR: res = word & ~mask;
         OP_SET: res = word | mask;
`ifdef FB_TOGGLE_EN
         OP_TGL: res = word ^ mask;
`endif
         default: res = word;
      endcase
      return res;
   endfunction

   // Scanout stage p0 -> p1: address presented to RAM, bit select and range flag registered
   logic                   in_rng_p0;
   logic [ADDR_W-1:0]      addr_a_p0;
   logic                   in_rng_p1;
   logic [BIT_W-1:0]       bit_p1;
   logic [WORD_W-1:0]      q_a_p1;

   assign in_rng_p0 = in_range(x_a, y_a);
   assign addr_a_p0 = in_rng_p0 ? word_addr(x_a, y_a) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_rng_p1 <= 1'b0;
      end else begin
         in_rng_p1 <= in_rng_p0;
      end
   end

   always_ff @(posedge clk) begin
      bit_p1 <= x_a[BIT_W-1:0];
   end

   assign in_a = in_rng_p1 & q_a_p1[bit_p1];

   // Command stage: capture on accept, then RD/WR read-modify-write or CLR sweep
   fb_state_t         state;
   fb_state_t         state_nxt;
   logic              accept;
   logic              op_drop;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BIT_W-1:0]  bit_q;
   logic              drop_q;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] addr_b;
   logic              we_b;
   logic [WORD_W-1:0] d_b;
   logic [WORD_W-1:0] q_b;

   assign accept = wr_valid && wr_ready;

`ifdef FB_TOGGLE_EN
   assign op_drop = 1'b0;
`else
   assign op_drop = (wr_op == OP_TGL);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= wr_op;
         addr_q <= in_range(wr_x, wr_y) ? word_addr(wr_x, wr_y) : '0;
         bit_q  <= wr_x[BIT_W-1:0];
         drop_q <= !in_range(wr_x, wr_y) || op_drop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt <= '0;
      end else if (accept && (wr_op == OP_CLS)) begin
         clr_cnt <= '0;
      end else if (state == ST_CLR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      busy      = 1'b1;
      we_b      = 1'b0;
      addr_b    = addr_q;
      d_b       = merge_bit(q_b, bit_q, op_q);
      case (state)
         ST_IDLE: begin
            wr_ready = 1'b1;
            busy     = 1'b0;
            if (wr_valid) begin
               state_nxt = (wr_op == OP_CLS) ? ST_CLR : ST_RD;
            end
         end
         ST_RD: begin
            state_nxt = ST_WR;
         end
         ST_WR: begin
            we_b      = !drop_q;
            state_nxt = ST_IDLE;
         end
         ST_CLR: begin
            addr_b = clr_cnt;
            d_b    = '0;
            we_b   = 1'b1;
            if (clr_cnt == ADDR_W'(FB_WORDS - 1)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   fb_ram #(
      .DEPTH (FB_WORDS),
      .AW    (ADDR_W),
      .DW    (WORD_W)
   ) u_ram (
      .clk    (clk),
      .addr_a (addr_a_p0),
      .q_a    (q_a_p1),
      .addr_b (addr_b),
      .we_b   (we_b),
      .d_b    (d_b),
      .q_b    (q_b)
   );

endmodule

// File: tb/tb_framebuffer.sv
// Self-checking bench for framebuffer: pixel-array reference model, randomized
// pixel commands, clear-screen timing and reset-abort behaviour.
module tb_framebuffer;

   localparam int W = 320;
   localparam int H = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] x_a;
   logic [7:0] y_a;
   logic       in_a;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_op;
   logic [8:0] wr_x;
   logic [7:0] wr_y;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   bit mdl [H][W];

   always #5 clk = ~clk;

   framebuffer dut (
      .clk      (clk),
      .rst      (rst),
      .x_a      (x_a),
      .y_a      (y_a),
      .in_a     (in_a),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_op    (wr_op),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .busy     (busy)
   );

   function automatic bit exp_px(input int x, input int y);
      if (x >= W || y >= H) return 1'b0;
      return mdl[y][x];
   endfunction

   function automatic void model_apply(input int op, input int x, input int y);
      if (op == 3) begin
         for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
               mdl[yy][xx] = 1'b0;
      end else if (x < W && y < H) begin
         case (op)
            0: mdl[y][x] = 1'b0;
            1: mdl[y][x] = 1'b1;
`ifdef FB_TOGGLE_EN
            2: mdl[y][x] = ~mdl[y][x];
`endif
            default: ;
         endcase
      end
   endfunction

   task automatic read_px(input int x, input int y, output logic v);
      x_a = 9'(x);
      y_a = 8'(y);
      @(posedge clk);
      #1;
      v = in_a;
   endtask

   // Pixel command with handshake timing checks; optionally probes the word during its write cycle.
   task automatic send_cmd(input int op, input int x, input int y, input bit rbw);
      bit old;
      old = exp_px(x, y);
      n_checks++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready_pre op=%0d (%0d,%0d): wr_ready=%b expected 1", op, x, y, wr_ready);
      end
      wr_valid = 1'b1;
      wr_op    = 2'(op);
      wr_x     = 9'(x);
      wr_y     = 8'(y);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_op    = 2'($urandom);
      wr_x     = 9'($urandom);
      wr_y     = 8'($urandom);
      n_checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_cycle1 op=%0d (%0d,%0d): wr_ready=%b busy=%b expected 0/1", op, x, y, wr_ready, busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_cycle2 op=%0d (%0d,%0d): wr_ready=%b busy=%b expected 0/1", op, x, y, wr_ready, busy);
      end
      if (rbw) begin
         x_a = 9'(x);
         y_a = 8'(y);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cmd_cycle3 op=%0d (%0d,%0d): wr_ready=%b busy=%b expected 1/0", op, x, y, wr_ready, busy);
      end
      if (rbw) begin
         n_checks++;
         if (in_a !== old) begin
            n_fail++;
            $display("FAIL read_before_write (%0d,%0d): in_a=%b expected old %b", x, y, in_a, old);
         end
      end
      model_apply(op, x, y);
   endtask

   task automatic scan_rows(input string tag);
      logic v;
      int   y;
      for (int r = 0; r <= 25; r++) begin
         y = (r == 25) ? H - 1 : r * 8;
         for (int x = 0; x < W; x++) begin
            read_px(x, y, v);
            n_checks++;
            if (v !== exp_px(x, y)) begin
               n_fail++;
               $display("FAIL %s scan (%0d,%0d): in_a=%b expected %b", tag, x, y, v, exp_px(x, y));
            end
         end
      end
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_op    = 2'd0;
      wr_x     = '0;
      wr_y     = '0;
      x_a      = '0;
      y_a      = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (in_a !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_held: in_a=%b busy=%b wr_ready=%b expected 0/0/1", in_a, busy, wr_ready);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_a !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: in_a=%b busy=%b wr_ready=%b expected 0/0/1", in_a, busy, wr_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_clear;
      wr_valid = 1'b1;
      wr_op    = 2'd3;
      wr_x     = 9'($urandom);
      wr_y     = 8'($urandom);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_op    = 2'($urandom);
   endtask

   task automatic test_clear_screen;
      int   cyc;
      logic v;
      start_clear();
      n_checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL cls_cycle1: busy=%b wr_ready=%b expected 1/0", busy, wr_ready);
      end
      cyc = 1;
      while (wr_ready !== 1'b1 && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (cyc != 4001) begin
         n_fail++;
         $display("FAIL cls_ready_cycle: wr_ready rose at cycle %0d expected 4001", cyc);
      end
      model_apply(3, 0, 0);
      scan_rows("after_cls");
      read_px(320, 0, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL lookahead_320_0: in_a=%b expected 0", v); end
      read_px(0, 200, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL row_200: in_a=%b expected 0", v); end
   endtask

   task automatic test_set_pixel;
      logic v;
      send_cmd(1, 17, 5, 1'b0);
      read_px(17, 5, v);
      n_checks++;
      if (v !== 1'b1) begin n_fail++; $display("FAIL set_17_5: in_a=%b expected 1", v); end
      read_px(16, 5, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL neighbour_16_5: in_a=%b expected 0", v); end
      read_px(17, 6, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL neighbour_17_6: in_a=%b expected 0", v); end
   endtask

   task automatic test_corner;
      logic v;
      send_cmd(1, 319, 199, 1'b0);
      read_px(319, 199, v);
      n_checks++;
      if (v !== 1'b1) begin n_fail++; $display("FAIL corner_set: in_a=%b expected 1", v); end
      read_px(320, 199, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL corner_lookahead: in_a=%b expected 0", v); end
      send_cmd(0, 319, 199, 1'b0);
      read_px(319, 199, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL corner_clear: in_a=%b expected 0", v); end
      read_px(320, 0, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL oor_320_0: in_a=%b expected 0", v); end
      read_px(0, 200, v);
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL oor_0_200: in_a=%b expected 0", v); end
   endtask

   task automatic test_out_of_range;
      logic v;
      send_cmd(1, 400, 10, 1'b0);
      read_px(80, 11, v);
      n_checks++;
      if (v !== exp_px(80, 11)) begin
         n_fail++;
         $display("FAIL oor_alias_80_11: in_a=%b expected %b", v, exp_px(80, 11));
      end
      send_cmd(1, 5, 230, 1'b0);
      scan_rows("after_oor");
   endtask

   task automatic test_toggle;
      logic v;
      for (int k = 0; k < 2; k++) begin
         send_cmd(2, 3, 3, 1'b0);
         read_px(3, 3, v);
         n_checks++;
         if (v !== exp_px(3, 3)) begin
            n_fail++;
            $display("FAIL toggle_%0d: in_a=%b expected %b", k, v, exp_px(3, 3));
         end
      end
   endtask

   task automatic test_read_before_write;
      logic v;
      send_cmd(1, 50, 60, 1'b1);
      read_px(50, 60, v);
      n_checks++;
      if (v !== 1'b1) begin n_fail++; $display("FAIL rbw_after: in_a=%b expected 1", v); end
      send_cmd(0, 50, 60, 1'b1);
   endtask

   task automatic test_back_to_back;
      logic v;
      int   op, x, y;
      for (int k = 0; k < 120; k++) begin
         op = $urandom_range(0, 2);
         x  = ($urandom_range(0, 9) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 63);
         y  = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 255) : $urandom_range(16, 31);
         send_cmd(op, x, y, 1'b0);
      end
      for (int yy = 16; yy < 32; yy++) begin
         for (int xx = 0; xx < 64; xx++) begin
            read_px(xx, yy, v);
            n_checks++;
            if (v !== exp_px(xx, yy)) begin
               n_fail++;
               $display("FAIL b2b_region (%0d,%0d): in_a=%b expected %b", xx, yy, v, exp_px(xx, yy));
            end
         end
      end
      scan_rows("after_b2b");
   endtask

   task automatic test_reset_during_clear;
      logic v;
      int   w;
      for (int k = 0; k < 8; k++)
         send_cmd(1, $urandom_range(0, 319), $urandom_range(0, 3), 1'b0);
      send_cmd(1, 300, 4, 1'b0);
      send_cmd(1, 5, 150, 1'b0);
      start_clear();
      repeat (99) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_in_reset: busy=%b wr_ready=%b expected 0/1", busy, wr_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_after_release: busy=%b wr_ready=%b expected 0/1", busy, wr_ready);
      end
      for (int wd = 0; wd < 99; wd++)
         for (int b = 0; b < 16; b++)
            mdl[wd / 20][(wd % 20) * 16 + b] = 1'b0;
      for (int yy = 0; yy < 5; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            w = yy * 20 + xx / 16;
            if (w < 99) begin
               read_px(xx, yy, v);
               n_checks++;
               if (v !== exp_px(xx, yy)) begin
                  n_fail++;
                  $display("FAIL abort_cleared (%0d,%0d): in_a=%b expected %b", xx, yy, v, exp_px(xx, yy));
               end
            end
         end
      end
      for (int xx = 0; xx < 16; xx++) begin
         read_px(xx, 150, v);
         n_checks++;
         if (v !== exp_px(xx, 150)) begin
            n_fail++;
            $display("FAIL abort_word3000 (%0d,150): in_a=%b expected %b", xx, v, exp_px(xx, 150));
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clear_screen();
      test_set_pixel();
      test_corner();
      test_out_of_range();
      test_toggle();
      test_read_before_write();
      test_back_to_back();
      test_reset_during_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
